ps2_key_decoder: RTL

- PS/2 keyboard receiver for the 2048 top level.
- Deserialises host-bound PS/2 frames and tracks make/break codes for the four arrow keys and the 's' key.
- Produces held-key levels and one-cycle press pulses that drive the game's direction and start inputs in place of KEY[3:0] and SW[0].
- Sits between the board PS2_CLK/PS2_DAT pins and the control FSM, in the CLOCK_50 domain.

---
 rtl/ps2_codes_pkg.sv | 23 ++
 rtl/ps2_rx_frame.sv | 99 +++++++++
 rtl/ps2_key_decoder.sv | 98 +++++++++
 3 files changed

// File: rtl/ps2_codes_pkg.sv
// ps2_codes_pkg: PS/2 scancode constants, direction bit indices, FSM encodings, arrow decode helper
package ps2_codes_pkg;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;
   typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BREAK, DEC_EXT_BREAK} dec_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   // one-hot direction mask for an extended arrow code, 0 for anything else
   function automatic logic [3:0] arrow_mask(input logic [7:0] code);
      return (code == SC_UP)    ? 4'b0001 << DIR_UP :
             (code == SC_DOWN)  ? 4'b0001 << DIR_DOWN :
             (code == SC_LEFT)  ? 4'b0001 << DIR_LEFT :
             (code == SC_RIGHT) ? 4'b0001 << DIR_RIGHT : 4'b0000;
   endfunction
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises PS/2 clock/data and deserialises 11-bit frames with a stall timeout
// ports: clock, reset (sync, active-high), ps2_clk/ps2_dat (raw async), rx_byte + byte_valid strobe, frame_err strobe
module ps2_rx_frame import ps2_codes_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic                   clk_prev_q, clk_prev_d;
   rx_state_t              state_q, state_d;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d, byte_q, byte_d;
   logic                   par_q, par_d, valid_q, valid_d, err_q, err_d;
   logic [CW-1:0]          tmo_q, tmo_d;
   logic                   clk_s, dat_s, fall, timeout;
   always_comb begin
      clk_sync_d = SYNC_STAGES'({clk_sync_q, ps2_clk});
      dat_sync_d = SYNC_STAGES'({dat_sync_q, ps2_dat});
      clk_s      = clk_sync_q[SYNC_STAGES-1];
      dat_s      = dat_sync_q[SYNC_STAGES-1];
      clk_prev_d = clk_s;
      fall       = clk_prev_q & ~clk_s;
      // a fall in the same cycle as expiry counts as activity, so it wins
      timeout    = (state_q != RX_IDLE) && !fall && (tmo_q == CW'(TIMEOUT_CYCLES - 1));
      tmo_d      = (fall || state_q == RX_IDLE) ? '0 : tmo_q + 1'b1;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      byte_d     = byte_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      if (timeout) begin
         state_d = RX_IDLE;
         err_d   = 1'b1;
      end else if (fall) begin
         case (state_q)
            RX_IDLE: begin
               state_d   = dat_s ? RX_IDLE : RX_DATA;
               err_d     = dat_s;
               bit_cnt_d = '0;
            end
            RX_DATA: begin
               shift_d   = {dat_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               state_d   = (bit_cnt_q == 3'd7) ? RX_PARITY : RX_DATA;
            end
            RX_PARITY: begin
               par_d   = dat_s;
               state_d = RX_STOP;
            end
            default: begin
               state_d = RX_IDLE;
               valid_d = dat_s & (^{shift_q, par_q});
               err_d   = ~valid_d;
               byte_d  = valid_d ? shift_q : byte_q;
            end
         endcase
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         clk_sync_q <= '0;
         dat_sync_q <= '0;
         clk_prev_q <= 1'b0;
         state_q    <= RX_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         byte_q     <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         tmo_q      <= '0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         clk_prev_q <= clk_prev_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         byte_q     <= byte_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         tmo_q      <= tmo_d;
      end
   end
   assign rx_byte    = byte_q;
   assign byte_valid = valid_q;
   assign frame_err  = err_q;
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver tracking arrow keys and 's' as held levels and press pulses
// ports: clock, reset (sync, active-high), ps2_clk/ps2_dat (raw), direction/dir_pulse [3]=up [2]=down [1]=left [0]=right,
//        start/start_pulse for 's', scancode + scancode_valid strobe, frame_err strobe
module ps2_key_decoder import ps2_codes_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [3:0] direction,
   output logic [3:0] dir_pulse,
   output logic       start,
   output logic       start_pulse,
   output logic [7:0] scancode,
   output logic       scancode_valid,
   output logic       frame_err
);
   logic [7:0] rx_byte;
   logic       byte_valid, rx_err, is_s;
   logic [3:0] mask;
   dec_state_t state_q, state_d;
   logic [3:0] dir_q, dir_d, dpulse_q, dpulse_d;
   logic       start_q, start_d, spulse_q, spulse_d, valid_q, valid_d;
   logic [7:0] scancode_q, scancode_d;
   ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clock      (clock),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_dat    (ps2_dat),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (rx_err)
   );
   always_comb begin
      mask       = arrow_mask(rx_byte);
      is_s       = rx_byte == SC_S;
      state_d    = state_q;
      dir_d      = dir_q;
      start_d    = start_q;
      dpulse_d   = 4'b0000;
      spulse_d   = 1'b0;
      valid_d    = byte_valid;
      scancode_d = byte_valid ? rx_byte : scancode_q;
      if (byte_valid) begin
         case (state_q)
            DEC_BASE: begin
               state_d  = (rx_byte == SC_EXT) ? DEC_EXT : (rx_byte == SC_BREAK) ? DEC_BREAK : DEC_BASE;
               start_d  = start_q | is_s;
               spulse_d = is_s & ~start_q;
            end
            DEC_EXT: begin
               state_d  = (rx_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_BASE;
               dir_d    = dir_q | mask;
               dpulse_d = mask & ~dir_q;
            end
            DEC_BREAK: begin
               state_d = DEC_BASE;
               start_d = start_q & ~is_s;
            end
            default: begin
               state_d = DEC_BASE;
               dir_d   = dir_q & ~mask;
            end
         endcase
      end else if (rx_err) begin
         // a corrupted frame after a prefix would otherwise pair the prefix with an unrelated byte
         state_d = DEC_BASE;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= DEC_BASE;
         dir_q      <= '0;
         dpulse_q   <= '0;
         start_q    <= 1'b0;
         spulse_q   <= 1'b0;
         valid_q    <= 1'b0;
         scancode_q <= '0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         dpulse_q   <= dpulse_d;
         start_q    <= start_d;
         spulse_q   <= spulse_d;
         valid_q    <= valid_d;
         scancode_q <= scancode_d;
      end
   end
   assign direction      = dir_q;
   assign dir_pulse      = dpulse_q;
   assign start          = start_q;
   assign start_pulse    = spulse_q;
   assign scancode       = scancode_q;
   assign scancode_valid = valid_q;
   assign frame_err      = rx_err;
endmodule
